// File: rtl/exec_pipe_stage.sv
// exec_pipe_stage: one-entry pipeline register with a skid buffer.
// The stage can absorb one extra entry, so in_ready depends only on registered
// state and never combinationally on out_ready.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   flush               synchronous kill of all held entries
//   in_valid/in_ready   upstream handshake
//   in_ctrl/in_data     upstream control bits and payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data   held control bits and payload, taken from the main register
//   occupancy           number of held entries (0..2)
//   stall_cnt           saturating count of cycles with out_valid=1 and out_ready=0
module exec_pipe_stage #(
  parameter int unsigned CTRL_W     = 12,
  parameter int unsigned DATA_W     = 160,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              r_state;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_in_xfer;
  logic                w_stall;
  logic                w_stall_sat;

  // Handshake status is decoded from the state register alone.
  assign in_ready    = (r_state != StTwo);
  assign out_valid   = (r_state != StEmpty);
  assign w_in_xfer   = in_valid & in_ready;
  assign w_stall     = out_valid & ~out_ready;
  assign w_stall_sat = &r_stall_cnt;

  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StEmpty;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_stall_cnt <= '0;
      if (CLEAR_DATA != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      // Stall accounting is independent of flush.
      if (w_stall && !w_stall_sat) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (flush) begin
        // Any same-cycle in transfer is dropped; an out transfer already happened.
        r_state     <= StEmpty;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end
      end else begin
        case (r_state)
          StEmpty: begin
            if (w_in_xfer) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
              r_state     <= StOne;
            end
          end
          StOne: begin
            if (w_in_xfer && out_ready) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end else if (w_in_xfer) begin
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
              r_state     <= StTwo;
            end else if (out_ready) begin
              // Draining to empty leaves a bubble on the output.
              r_main_ctrl <= '0;
              if (CLEAR_DATA != 0) begin
                r_main_data <= '0;
              end
              r_state <= StEmpty;
            end
          end
          StTwo: begin
            if (out_ready) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
              r_state     <= StOne;
            end
          end
          default: r_state <= StEmpty;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_pipe_stage.sv
// Directed and randomized checks for exec_pipe_stage.
// Instance a: CLEAR_DATA=1, CNT_W=3 for directed vectors.
// Instance b: CLEAR_DATA=0 for a random handshake run against a reference queue.
module tb_exec_pipe_stage;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset, flush;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [2:0]    a_stall;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exec_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1), .CNT_W(3)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  exec_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic rdy);
    a_in_valid  = v;
    a_in_data   = d;
    a_in_ctrl   = d[CW-1:0] ^ 8'h5A;
    a_out_ready = rdy;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] seq;
  logic          in_x, out_x;

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive_a(1'b1, 32'hFFFF, 1'b1);
    b_in_valid = 1'b1; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0);
    b_in_valid = 1'b0;
    tick();
    check_eq("rst_out_valid", a_out_valid, 1'b0);
    check_eq("rst_out_ctrl",  a_out_ctrl, '0);
    check_eq("rst_in_ready",  a_in_ready, 1'b1);
    check_eq("rst_occ",       a_occ, 2'd0);
    check_eq("rst_stall",     a_stall, 3'd0);
    check_eq("rst_out_data",  a_out_data, '0);

    // Streaming 1..4 with out_ready held high.
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, DW'(i), 1'b1);
      tick();
      check_eq($sformatf("stream_data%0d", i), a_out_data, 64'(i));
      check_eq($sformatf("stream_ctrl%0d", i), a_out_ctrl, 64'(i ^ 8'h5A));
      check_eq($sformatf("stream_occ%0d", i), a_occ, 2'd1);
    end
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    check_eq("drain_valid", a_out_valid, 1'b0);
    check_eq("drain_ctrl",  a_out_ctrl, '0);
    check_eq("drain_data",  a_out_data, '0);
    check_eq("stream_stall", a_stall, 3'd0);

    // Skid: A loaded, B arrives under backpressure.
    drive_a(1'b1, 32'hA, 1'b0);
    tick();
    check_eq("skid_a_loaded", a_out_data, 32'hA);
    check_eq("skid_stall0", a_stall, 3'd0);
    drive_a(1'b1, 32'hB, 1'b0);
    tick();
    check_eq("skid_occ2", a_occ, 2'd2);
    check_eq("skid_in_ready", a_in_ready, 1'b0);
    check_eq("skid_hold_a", a_out_data, 32'hA);
    check_eq("skid_stall1", a_stall, 3'd1);
    drive_a(1'b0, 32'h0, 1'b0);
    tick();
    check_eq("skid_stall2", a_stall, 3'd2);
    check_eq("skid_hold_a2", a_out_data, 32'hA);
    check_eq("skid_hold_ctrl", a_out_ctrl, 8'h0A ^ 8'h5A);
    tick();
    check_eq("skid_stall3", a_stall, 3'd3);
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    check_eq("skid_b_out", a_out_data, 32'hB);
    check_eq("skid_occ1", a_occ, 2'd1);
    tick();
    check_eq("skid_empty", a_out_valid, 1'b0);
    check_eq("skid_stall_keep", a_stall, 3'd3);

    // Flush in TWO with C offered in the same cycle.
    drive_a(1'b1, 32'hD, 1'b0);
    tick();
    drive_a(1'b1, 32'hE, 1'b0);
    tick();
    check_eq("fl_occ2", a_occ, 2'd2);
    check_eq("fl_stall4", a_stall, 3'd4);
    flush = 1'b1;
    drive_a(1'b1, 32'hC, 1'b1);
    tick();
    check_eq("fl_valid", a_out_valid, 1'b0);
    check_eq("fl_ctrl", a_out_ctrl, '0);
    check_eq("fl_occ", a_occ, 2'd0);
    check_eq("fl_in_ready", a_in_ready, 1'b1);
    check_eq("fl_data", a_out_data, '0);
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    check_eq("fl_no_c", a_out_valid, 1'b0);
    check_eq("fl_stall_kept", a_stall, 3'd4);

    // Reset in TWO with stall_cnt=5; inputs during reset are ignored.
    drive_a(1'b1, 32'hF1, 1'b0);
    tick();
    drive_a(1'b1, 32'hF2, 1'b0);
    tick();
    check_eq("rt_occ2", a_occ, 2'd2);
    check_eq("rt_stall5", a_stall, 3'd5);
    reset = 1'b1;
    drive_a(1'b1, 32'hF3, 1'b0);
    tick();
    check_eq("rt_occ", a_occ, 2'd0);
    check_eq("rt_stall", a_stall, 3'd0);
    check_eq("rt_ctrl", a_out_ctrl, '0);
    check_eq("rt_data", a_out_data, '0);
    reset = 1'b0;
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    check_eq("rt_no_valid", a_out_valid, 1'b0);

    // Saturation of the 3-bit stall counter.
    drive_a(1'b1, 32'h77, 1'b0);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("sat_stall7", a_stall, 3'd7);
    check_eq("sat_hold_data", a_out_data, 32'h77);
    tick();
    check_eq("sat_stall_hold", a_stall, 3'd7);
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    check_eq("sat_drained", a_out_valid, 1'b0);
    drive_a(1'b0, 32'h0, 1'b0);

    // Random handshakes on instance b against a reference queue.
    seq = 32'h100;
    for (int c = 0; c < 400; c++) begin
      check_eq("rnd_occ", b_occ, 64'(q.size()));
      check_eq("rnd_valid", b_out_valid, (q.size() != 0));
      check_eq("rnd_in_ready", b_in_ready, (q.size() < 2));
      if (q.size() != 0) check_eq("rnd_data", b_out_data, q[0]);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (c > 200) b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = seq;
      b_in_ctrl   = seq[CW-1:0];
      in_x  = b_in_valid & b_in_ready;
      out_x = b_out_valid & b_out_ready;
      if (out_x && q.size() != 0) void'(q.pop_front());
      if (in_x) begin
        q.push_back(seq);
        seq = seq + 1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_pipe_stage.md
EXEC_PIPE_STAGE -- requirements
Module: exec_pipe_stage

Interface
REQ-001 Parameter CTRL_W, default 12: width of the control field, which is cleared on flush and on reset.
REQ-002 Parameter DATA_W, default 160: width of the data field (operands, PC, immediates, register indices).
REQ-003 Parameter CLEAR_DATA, default 1: 1 zeroes the data field on flush and on reset; 0 holds its last value.
REQ-004 Parameter CNT_W, default 16: width of the stall counter.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous kill of all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 out_valid  out  1  downstream entry present.
REQ-013 out_ready  in  1  downstream accepts this cycle.
REQ-014 out_ctrl  out  CTRL_W  held control bits.
REQ-015 out_data  out  DATA_W  held payload.
REQ-016 occupancy  out  2  entries held (0, 1 or 2).
REQ-017 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 A transfer SHALL occur on a port when valid=1 and ready=1 in the same cycle.
REQ-019 Storage SHALL be a main register driving the outputs plus one skid register; the FSM states are EMPTY, ONE and TWO.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, derived from state registers only, with no combinational path from out_ready.
REQ-021 EMPTY: on an in transfer, load main and go to ONE; otherwise stay in EMPTY.
REQ-022 ONE: in transfer with out_ready=1 loads main and stays in ONE; in transfer with out_ready=0 loads skid and goes to TWO; no in transfer with out_ready=1 goes to EMPTY; otherwise hold.
REQ-023 TWO: out_ready=1 moves skid into main and goes to ONE; otherwise hold.
REQ-024 out_valid SHALL be 1 in ONE and TWO; out_ctrl and out_data SHALL come from main.
REQ-025 In EMPTY, out_ctrl SHALL be 0 (bubble); out_data SHALL be 0 when CLEAR_DATA=1, else the last value.
REQ-026 Latency SHALL be 1 cycle from an in transfer into EMPTY to out_valid=1.
REQ-027 Sustained throughput SHALL be 1 entry per cycle with no bubbles while out_ready=1.
REQ-028 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-029 While out_valid=1 and out_ready=0, out_ctrl and out_data SHALL stay stable.
REQ-030 occupancy SHALL be 0, 1 or 2 in EMPTY, ONE or TWO respectively.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0.
REQ-031a stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL be unaffected by flush.
REQ-032 On flush=1, the next state SHALL be EMPTY.
REQ-032a On flush=1, the main and skid control fields SHALL be zeroed, and the data fields SHALL be zeroed if CLEAR_DATA=1.
REQ-033 An in transfer in the same cycle as flush SHALL be discarded.
REQ-033a An out transfer in the same cycle as flush SHALL count as delivered.
REQ-034 in_ready SHALL be 1 in the cycle after a flush.
REQ-035 reset SHALL take priority over flush; flush SHALL take priority over handshakes.

Reset
REQ-036 While reset=1, inputs SHALL be ignored, and on the next edge the state SHALL become EMPTY.
REQ-036a On that edge, the control fields, occupancy and stall_cnt SHALL become 0, and the data fields SHALL become 0 if CLEAR_DATA=1.
REQ-037 From the first cycle after reset deasserts: out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
REQ-038 Reset asserted mid-operation (state ONE or TWO) SHALL drop all entries, with no out_valid=1 afterwards until a new in transfer.

Verification
REQ-039 Streaming: out_ready=1, in_valid=1 for 4 cycles with in_data 1..4 -> out_data 1..4 on the next 4 cycles; occupancy stays at 1; stall_cnt=0.
REQ-040 Skid: state ONE with entry A, send B while out_ready=0 -> occupancy=2, in_ready=0, out_data=A held, stall_cnt increments per cycle; then out_ready=1 -> A, then B.
REQ-041 Flush in TWO with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears at the output.
REQ-042 Saturation: CNT_W=3, out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=7, then holds.
REQ-043 Reset in TWO with stall_cnt=5 -> next cycle occupancy=0, stall_cnt=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1).
REQ-044 Random valid/ready with CLEAR_DATA=0 against a reference queue -> output order matches, occupancy never exceeds 2, out fields stable under backpressure.
